// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: round-robin arbiter sharing one serial bin-to-BCD converter.
// Optional watchdog enabled by defining BCD_CONV_ARB_WATCHDOG_EN.
`timescale 1ns/1ps
module bcd_conv_arb #(
    parameter int N_REQ   = 4,
    parameter int DEC_W   = 8,
    parameter int BIN_W   = $clog2(10**DEC_W),
    parameter int TIMEOUT = BIN_W + 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][BIN_W-1:0] req_bin,
    output logic [N_REQ-1:0]            rsp_vld,
    output logic [DEC_W*4-1:0]          rsp_bcd,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    gnt_id,
    output logic [BIN_W-1:0]            cv_in,
    output logic                        cv_conv,
    input  logic                        cv_rdy,
    input  logic [DEC_W*4-1:0]          cv_out,
    output logic                        err
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        WAIT_RDY,
        IDLE,
        START,
        ARM,
        BUSY,
        DONE
    } state_t;

    state_t              state_q;
    logic [GW-1:0]       ptr_q;
    logic [GW-1:0]       gnt_q;
    logic [N_REQ-1:0]    vld_q;
    logic [DEC_W*4-1:0]  bcd_q;
    logic                busy_q;
    logic [BIN_W-1:0]    cvin_q;
    logic                conv_q;
    logic                arm_q;

    logic [GW-1:0]       gnt_d;
    logic                gnt_vld;
    logic [GW-1:0]       ptr_d;

    function automatic logic [GW-1:0] wrap(input int k);
        return (k >= N_REQ) ? GW'(k - N_REQ) : GW'(k);
    endfunction

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_d   = ptr_q;
        gnt_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap(int'(ptr_q) + i)]) begin
                gnt_d   = wrap(int'(ptr_q) + i);
                gnt_vld = 1'b1;
            end
        end
    end

    // Served requester becomes lowest priority next time.
    assign ptr_d = (gnt_q == GW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

`ifdef BCD_CONV_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [1:0]    rty_q;
    logic          err_q;
    logic          in_wait;
    logic          rty_trip;
    logic          wd_fire;

    assign in_wait  = (state_q == ARM) || (state_q == BUSY);
    assign rty_trip = (state_q == ARM) && cv_rdy && arm_q &&
                      (rty_q == 2'd3);
    assign wd_fire  = in_wait &&
                      ((cnt_q == CW'(TIMEOUT - 1)) || rty_trip);

    // Cycle counter over ARM/BUSY, retry count and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            rty_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == IDLE)
                rty_q <= '0;
            if (state_q == START)
                cnt_q <= '0;
            else if (in_wait)
                cnt_q <= cnt_q + 1'b1;
            if ((state_q == ARM) && cv_rdy && arm_q && (rty_q != 2'd3))
                rty_q <= rty_q + 1'b1;
            if (wd_fire)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Grant, converter handshake and result return sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_RDY;
            ptr_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            cvin_q  <= '0;
            conv_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            vld_q <= '0;
            unique case (state_q)
                WAIT_RDY: begin
                    if (cv_rdy)
                        state_q <= IDLE;
                end
                IDLE: begin
                    if (gnt_vld) begin
                        gnt_q   <= gnt_d;
                        cvin_q  <= req_bin[gnt_d];
                        conv_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    conv_q  <= 1'b0;
                    arm_q   <= 1'b0;
                    state_q <= ARM;
                end
                ARM: begin
                    if (!cv_rdy) begin
                        state_q <= BUSY;
                    end else if (arm_q) begin
                        conv_q  <= 1'b1;
                        state_q <= START;
                    end else begin
                        arm_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cv_rdy) begin
                        bcd_q   <= cv_out;
                        vld_q   <= N_REQ'(1) << gnt_q;
                        ptr_q   <= ptr_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= WAIT_RDY;
            endcase
`ifdef BCD_CONV_ARB_WATCHDOG_EN
            if (wd_fire) begin
                bcd_q   <= '1;
                vld_q   <= N_REQ'(1) << gnt_q;
                ptr_q   <= ptr_d;
                busy_q  <= 1'b0;
                conv_q  <= 1'b0;
                state_q <= WAIT_RDY;
            end
`endif
        end
    end

    assign rsp_vld = vld_q;
    assign rsp_bcd = bcd_q;
    assign busy    = busy_q;
    assign gnt_id  = gnt_q;
    assign cv_in   = cvin_q;
    assign cv_conv = conv_q;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// tb_bcd_conv_arb: directed and random checks of the arbiter against a
// behavioural converter and an arithmetic round-robin reference.
`timescale 1ns/1ps
module tb_bcd_conv_arb;

    localparam int N_REQ    = 4;
    localparam int DEC_W    = 4;
    localparam int BIN_W    = 14;
    localparam int TIMEOUT  = BIN_W + 8;
    localparam int GW       = 2;
    localparam int CONV_LAT = BIN_W + 3;
    localparam int E2E      = BIN_W + 6;
    localparam int BOUND    = 4 * BIN_W + 64;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [N_REQ-1:0]            req = '0;
    logic [N_REQ-1:0][BIN_W-1:0] req_bin = '0;
    logic [N_REQ-1:0]            rsp_vld;
    logic [DEC_W*4-1:0]          rsp_bcd;
    logic                        busy;
    logic [GW-1:0]               gnt_id;
    logic [BIN_W-1:0]            cv_in;
    logic                        cv_conv;
    logic                        cv_rdy;
    logic [DEC_W*4-1:0]          cv_out;
    logic                        err;

    int errs = 0;
    int checks = 0;
    int exp_ptr = 0;
    int c0, g, id, v, lat;
    int vals[3] = '{9999, 0, 1234};

    bcd_conv_arb #(
        .N_REQ(N_REQ), .DEC_W(DEC_W), .BIN_W(BIN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_bin(req_bin),
        .rsp_vld(rsp_vld), .rsp_bcd(rsp_bcd), .busy(busy),
        .gnt_id(gnt_id), .cv_in(cv_in), .cv_conv(cv_conv),
        .cv_rdy(cv_rdy), .cv_out(cv_out), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DEC_W*4-1:0] to_bcd(input int val);
        logic [DEC_W*4-1:0] r;
        r = '0;
        for (int i = 0; i < DEC_W; i++) begin
            r[i*4 +: 4] = 4'(val % 10);
            val = val / 10;
        end
        return r;
    endfunction

    function automatic int next_grant(input logic [N_REQ-1:0] m);
        for (int k = 0; k < N_REQ; k++)
            if (m[(exp_ptr + k) % N_REQ])
                return (exp_ptr + k) % N_REQ;
        return -1;
    endfunction

    // Behavioural converter: busy CONV_LAT cycles per accepted start,
    // BIN_W+2 cycles of dummy conversion after reset.
    int                 m_cnt = BIN_W + 2;
    int                 m_seen = 0;
    int                 ign_at = -1;
    logic               m_stuck = 1'b0;
    logic [DEC_W*4-1:0] m_res = '0;

    assign cv_rdy = (m_cnt == 0) && !m_stuck;
    assign cv_out = m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= BIN_W + 2;
            m_res <= '0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else if (cv_conv && cv_rdy) begin
            m_seen <= m_seen + 1;
            if (m_seen != ign_at) begin
                m_cnt <= CONV_LAT;
                m_res <= to_bcd(int'(cv_in));
            end
        end
    end

    int               n_conv = 0;
    logic [BIN_W-1:0] last_in = '0;

    always @(posedge clk) begin
        if (!rst && cv_conv) begin
            n_conv  <= n_conv + 1;
            last_in <= cv_in;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input string tag, input int rid,
                              input logic [DEC_W*4-1:0] bcd,
                              input int elat,
                              input logic [N_REQ-1:0] drop);
        int cyc;
        bit ok;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            chk({tag, "_onehot"}, 64'($onehot0(rsp_vld)), 64'(1));
            ok = |rsp_vld;
        end
        chk({tag, "_seen"}, 64'(ok), 64'(1));
        if (elat != 0)
            chk({tag, "_lat"}, 64'(cyc), 64'(elat));
        chk({tag, "_id"}, 64'(rsp_vld), 64'(1) << rid);
        chk({tag, "_gnt"}, 64'(gnt_id), 64'(rid));
        chk({tag, "_bcd"}, 64'(rsp_bcd), 64'(bcd));
        exp_ptr = (rid + 1) % N_REQ;
        req = req & ~drop;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(rsp_vld), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        req_bin[1] = BIN_W'(9999);
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out",
            64'({rsp_vld, rsp_bcd, busy, gnt_id, cv_in, cv_conv, err}),
            64'(0));
        rst = 1'b0;
        exp_ptr = 0;
        c0 = n_conv;
        repeat (BIN_W + 2) begin
            @(negedge clk);
            chk("wait_rdy_busy", 64'(busy), 64'(0));
        end
        chk("wait_rdy_conv", 64'(n_conv - c0), 64'(0));
        expect_rsp("first", 1, to_bcd(9999), BIN_W + 7, 4'b0010);

        foreach (vals[k]) begin
            c0 = n_conv;
            req_bin[1] = BIN_W'(vals[k]);
            req[1] = 1'b1;
            expect_rsp("dir", 1, to_bcd(vals[k]), E2E, 4'b0010);
            chk("dir_nconv", 64'(n_conv - c0), 64'(1));
            chk("dir_cvin", 64'(last_in), 64'(vals[k]));
        end

        for (int k = 0; k < 6; k++) begin
            id = int'($urandom_range(0, N_REQ - 1));
            v  = int'($urandom_range(0, 9999));
            req_bin[id] = BIN_W'(v);
            req = '0;
            req[id] = 1'b1;
            expect_rsp("rand", id, to_bcd(v), E2E, 4'b1111);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        for (int k = 0; k < N_REQ; k++)
            req_bin[k] = BIN_W'(10 * (k + 1));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = next_grant(req);
            expect_rsp("rr", g, to_bcd(10 * (g + 1)), 0,
                       (k == 4) ? 4'b1111 : 4'b0000);
        end

        req_bin[2] = BIN_W'(77);
        req_bin[3] = BIN_W'(88);
        req = 4'b1100;
        g = next_grant(req);
        repeat (6) @(negedge clk);
        req[2] = 1'b0;
        expect_rsp("drop", g, to_bcd(77), 0, 4'b0000);
        g = next_grant(req);
        expect_rsp("after_drop", g, to_bcd(88), 0, 4'b1000);

        req_bin[0] = BIN_W'(4321);
        req = 4'b0001;
        repeat (8) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 64'(1));
        #1 rst = 1'b1;
        #1 chk("async_rst", 64'({busy, rsp_vld, cv_conv}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_vld", 64'(rsp_vld), 64'(0));
        rst = 1'b0;
        exp_ptr = 0;
        expect_rsp("rst_reserve", 0, to_bcd(4321), 2 * BIN_W + 9, 4'b0001);

        c0 = n_conv;
        ign_at = m_seen;
        req_bin[2] = BIN_W'(555);
        req = 4'b0100;
        g = next_grant(req);
        expect_rsp("retry", g, to_bcd(555), E2E + 3, 4'b0100);
        chk("retry_nconv", 64'(n_conv - c0), 64'(2));
        ign_at = -1;

`ifdef BCD_CONV_ARB_WATCHDOG_EN
        m_stuck = 1'b1;
        req_bin[3] = BIN_W'(1);
        req = 4'b1000;
        g = next_grant(req);
        expect_rsp("wd", g, '1, 0, 4'b1000);
        chk("wd_err", 64'(err), 64'(1));
        chk("wd_busy", 64'(busy), 64'(0));
        m_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("wd_sticky", 64'(err), 64'(1));
        req_bin[0] = BIN_W'(42);
        req = 4'b0001;
        g = next_grant(req);
        expect_rsp("wd_recover", g, to_bcd(42), E2E, 4'b0001);
`else
        chk("err_zero", 64'(err), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
